// File: rtl/npu_dot3.sv
// rtl/npu_dot3.sv - signed dot-product MAC engine over VEC_LEN operand pairs
// Optional macro NPU_RELU_EN: clamp negative results to zero before loading out.
module npu_dot3 #(
    parameter int DATA_SIZE = 32,
    parameter int VEC_LEN   = 3,
    parameter int ACC_W     = 2*DATA_SIZE+2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] in1,
    input  logic [DATA_SIZE-1:0] in2,
    output logic                 ack,
    output logic [ACC_W-1:0]     out,
    output logic                 busy
);

    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN-1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_DONE} state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic [DATA_SIZE-1:0]     r_a [VEC_LEN];
    logic [DATA_SIZE-1:0]     r_b [VEC_LEN];
    logic signed [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]         r_out;
    logic                     r_ack;
    logic                     r_busy;

    logic signed [2*DATA_SIZE-1:0] w_a_ext;
    logic signed [2*DATA_SIZE-1:0] w_b_ext;
    logic signed [2*DATA_SIZE-1:0] w_prod;
    logic signed [ACC_W-1:0]       w_prod_ext;
    logic signed [ACC_W-1:0]       w_sum;
    logic [ACC_W-1:0]              w_result;

    // Operands are widened first so the product keeps full signed precision.
    assign w_a_ext    = {{DATA_SIZE{r_a[r_cnt][DATA_SIZE-1]}}, r_a[r_cnt]};
    assign w_b_ext    = {{DATA_SIZE{r_b[r_cnt][DATA_SIZE-1]}}, r_b[r_cnt]};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(ACC_W-2*DATA_SIZE){w_prod[2*DATA_SIZE-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

`ifdef NPU_RELU_EN
    assign w_result = w_sum[ACC_W-1] ? '0 : w_sum;
`else
    assign w_result = w_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_MAC: begin
                    r_acc <= w_sum;
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_out   <= w_result;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // IDLE, LOAD and DONE all accept operands; DONE capture gives back-to-back vectors.
                    if (en) begin
                        r_a[r_cnt] <= in1;
                        r_b[r_cnt] <= in2;
                        if (r_cnt == LAST) begin
                            r_state <= S_MAC;
                            r_cnt   <= '0;
                            r_acc   <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_cnt   <= r_cnt + CNT_W'(1);
                        end
                    end else if (r_state == S_DONE) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ack  = r_ack;
    assign out  = r_out;
    assign busy = r_busy;

endmodule

// File: tb/tb_npu_dot3.sv
// tb/tb_npu_dot3.sv - directed and randomized checks of npu_dot3 against a dot-product model
module tb_npu_dot3;
    localparam int DS = 32;
    localparam int V  = 3;
    localparam int AW = 2*DS+2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DS-1:0] in1;
    logic [DS-1:0] in2;
    logic          ack;
    logic          busy;
    logic [AW-1:0] out;

    int checks = 0;
    int errors = 0;

    logic signed [DS-1:0] va [V];
    logic signed [DS-1:0] vb [V];
    logic [AW-1:0]        last_out;

    npu_dot3 #(.DATA_SIZE(DS), .VEC_LEN(V), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .in1(in1), .in2(in2),
        .ack(ack), .out(out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] ref_dot();
        logic signed [AW-1:0] s;
        s = '0;
        for (int i = 0; i < V; i++)
            s = s + AW'(va[i]) * AW'(vb[i]);
`ifdef NPU_RELU_EN
        if (s < 0) s = '0;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [DS-1:0] a, input logic [DS-1:0] b);
        en  = e;
        in1 = a;
        in2 = b;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_vec(input int stall_idx, input int stall_n);
        for (int i = 0; i < V; i++) begin
            if (i == stall_idx) begin
                for (int s = 0; s < stall_n; s++) begin
                    step(1'b0, $urandom, $urandom);
                    chk("stall_busy", busy, 0);
                    chk("stall_ack", ack, 0);
                    chk("stall_out", out, last_out);
                end
            end
            step(1'b1, va[i], vb[i]);
            chk("load_ack", ack, 0);
            chk("load_busy", busy, (i == V-1));
            chk("load_out", out, last_out);
        end
    endtask

    task automatic mac_wait(input string tag);
        logic [AW-1:0] exp;
        exp = ref_dot();
        for (int k = 1; k <= V; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (k < V) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_early_ack"}, ack, 0);
            end else begin
                chk({tag, "_ack"}, ack, 1);
                chk({tag, "_out"}, out, exp);
                chk({tag, "_busy_done"}, busy, 0);
            end
        end
        last_out = exp;
    endtask

    task automatic idle_hold(input string tag);
        step(1'b0, $urandom, $urandom);
        chk({tag, "_ack_pulse"}, ack, 0);
        chk({tag, "_hold"}, out, last_out);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        en = 1'b0; in1 = '0; in2 = '0; rst = 1'b0;
        last_out = '0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        va = '{32'sd1, 32'sd2, 32'sd3};
        vb = '{32'sd4, 32'sd5, 32'sd6};
        send_vec(-1, 0);
        mac_wait("basic");
        idle_hold("basic");
        chk("basic_32", out, 66'd32);

        va = '{-32'sd1, 32'sd2, -32'sd3};
        vb = '{32'sd4, 32'sd5, 32'sd6};
        send_vec(-1, 0);
        mac_wait("signed");
        idle_hold("signed");

        va = '{32'h80000000, 32'h80000000, 32'h80000000};
        vb = '{32'h80000000, 32'h80000000, 32'h80000000};
        send_vec(-1, 0);
        mac_wait("ext_min");
        va = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        send_vec(-1, 0);
        mac_wait("ext_mix");
        idle_hold("ext_mix");

        va = '{32'sd1, 32'sd2, 32'sd3};
        vb = '{32'sd4, 32'sd5, 32'sd6};
        send_vec(2, 2);
        mac_wait("stall");
        va = '{32'sd1, 32'sd1, 32'sd1};
        vb = '{32'sd1, 32'sd1, 32'sd1};
        send_vec(-1, 0);
        mac_wait("b2b");
        idle_hold("b2b");

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < V; i++) begin
                va[i] = $urandom;
                vb[i] = $urandom;
            end
            send_vec($urandom_range(0, V), $urandom_range(1, 3));
            mac_wait("rand");
            if ($urandom_range(0, 1) == 1) idle_hold("rand");
        end

        va = '{32'sd5, 32'sd6, 32'sd7};
        vb = '{32'sd8, 32'sd9, 32'sd10};
        send_vec(-1, 0);
        step(1'b0, '0, '0);
        #2 rst = 1'b1;
        #1;
        chk("async_out", out, 0);
        chk("async_busy", busy, 0);
        chk("async_ack", ack, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        last_out = '0;
        for (int k = 0; k < V+2; k++) begin
            step(1'b0, $urandom, $urandom);
            chk("post_rst_ack", ack, 0);
            chk("post_rst_out", out, 0);
        end
        va = '{32'sd2, 32'sd2, 32'sd2};
        vb = '{32'sd2, 32'sd2, 32'sd2};
        send_vec(-1, 0);
        mac_wait("after_rst");
        chk("after_rst_12", out, 66'd12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
